comp_operand_loader: RTL and testbench
======================================

Name: comp_operand_loader

Overview:
- Upstream feeder for the 2-bit equality comparator stage.
- Receives operands x and y as a bit-serial pair stream, MSB first.
- Deserializes them into parallel WIDTH-bit words and presents them with a valid/ready handshake.
- Holds x/y stable for the comparator until the consumer acknowledges, then returns to idle for the next operand pair.

Parameters:
- WIDTH, 2, operand width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin (or restart) loading a new operand pair.
- ser_valid  input  1  ser_x/ser_y carry a valid bit this cycle.
- ser_x  input  1  serial bit of operand x.
- ser_y  input  1  serial bit of operand y.
- x  output  WIDTH  parallel operand x to the comparator; registered.
- y  output  WIDTH  parallel operand y to the comparator; registered.
- out_valid  output  1  x/y hold a complete, stable pair.
- out_ready  input  1  downstream accepts the pair.
- busy  output  1  high in SHIFT state.
- overrun  output  1  sticky: a serial bit arrived while not in SHIFT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cnt=0; shift registers=0.
  - x=0, y=0, out_valid=0, busy=0, overrun=0.
  - Reset mid-operation discards any partial word.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 -> SHIFT; cnt<=0; shift registers <=0; overrun<=0.
  - ser_valid=1 without start -> overrun<=1; bit ignored.
  - start together with ser_valid in the same cycle: the bit is NOT captured; capture begins next cycle.
- SHIFT:
  - Each cycle with ser_valid=1:
    - xs<={xs[WIDTH-2:0],ser_x}
    - ys<={ys[WIDTH-2:0],ser_y}
    - cnt<=cnt+1
  - ser_valid=0 -> stall; no change.
  - When ser_valid=1 and cnt==WIDTH-1:
    - x<={xs[WIDTH-2:0],ser_x}, y likewise.
    - out_valid<=1; cnt<=0; -> HOLD.
  - Latency: out_valid rises on the clock edge after the WIDTH-th accepted bit's cycle, i.e. 1 cycle after the last bit.
  - start=1 in SHIFT -> abort and restart: cnt<=0, shift registers<=0; any bit presented in that cycle is discarded.
- HOLD:
  - x, y, out_valid stable until out_valid&&out_ready.
  - On handshake:
    - start=1 same cycle -> SHIFT (back-to-back load); overrun cleared.
    - else -> IDLE.
  - out_valid<=0 on the following edge.
  - ser_valid=1 in HOLD -> overrun<=1; bit ignored; x/y unchanged.
  - start in HOLD without out_ready is ignored.
- x/y only update on the SHIFT->HOLD transition; they retain their last value through IDLE.
- busy = (state==SHIFT), registered-state decode.
- overrun clears only on an accepted start or on reset.

Optional Feature:
- Macro: COMP_LOADER_LSB_FIRST_EN.
- Defined: serial stream is LSB first.
  - xs<={ser_x,xs[WIDTH-1:1]}, same for ys.
  - Final word is {ser_x,xs[WIDTH-1:1]}.
  - All timing and handshakes are unchanged.
- Undefined: MSB first, as in Behaviour.

Decomposition:
- Package comp_pkg:
  - typedef enum loader_state_t {IDLE,SHIFT,HOLD}.
  - localparam COMP_WIDTH_DEFAULT=2.
- Sub-module comp_shift_reg (WIDTH, load-clear, shift-enable, parallel out):
  - Instantiated twice, for x and y.
  - Carries the COMP_LOADER_LSB_FIRST_EN direction switch.

Test Plan:
- Load 2-bit pair: start, then ser_valid bits (x,y)=(1,0),(0,1) -> one cycle after the 2nd bit, out_valid=1, x=2'b10, y=2'b01; out_ready=1 -> out_valid=0 next edge, state IDLE.
- Stall: WIDTH=2, bits separated by 3 idle cycles (ser_valid=0) -> same result x=2'b11, y=2'b11 for stream (1,1),(1,1); busy=1 throughout SHIFT.
- Backpressure plus overrun: hold out_ready=0 for 5 cycles with x=2'b01 presented, pulse ser_valid -> x/y stay 01, overrun=1; next start clears overrun.
- Abort: after 1 bit, assert start -> cnt resets; next 2 bits (0,0),(1,1) yield x=2'b01, y=2'b01.
- Back-to-back: out_ready and start in the same cycle in HOLD -> direct SHIFT; second pair x=2'b11, y=2'b00 loaded with no IDLE cycle.
- Async reset mid-SHIFT (rst_n low between clock edges) -> all outputs 0 immediately; COMP_LOADER_LSB_FIRST_EN run of stream (1,0),(0,1) gives x=2'b01, y=2'b10.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared types and defaults for the comparator operand loader.
// Contents:
//   loader_state_t      - loader FSM states (IDLE, SHIFT, HOLD)
//   COMP_WIDTH_DEFAULT  - default operand width in bits
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } loader_state_t;

    localparam int unsigned COMP_WIDTH_DEFAULT = 2;

endpackage

// File: rtl/comp_operand_loader_if.sv
// Bundle of the loader's serial input, parallel output handshake and status signals.
// Signals:
//   start, ser_valid, ser_x, ser_y - serial operand stream and load request
//   x, y, out_valid, out_ready     - parallel operand pair with valid/ready handshake
//   busy, overrun                  - status
// Modports: slave = loader side, master = stream producer / comparator side.
interface comp_operand_loader_if #(
    parameter int unsigned WIDTH = comp_pkg::COMP_WIDTH_DEFAULT
);
    logic             start;
    logic             ser_valid;
    logic             ser_x;
    logic             ser_y;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;

    modport slave (
        input  start, ser_valid, ser_x, ser_y, out_ready,
        output x, y, out_valid, busy, overrun
    );

    modport master (
        output start, ser_valid, ser_x, ser_y, out_ready,
        input  x, y, out_valid, busy, overrun
    );
endinterface

// File: rtl/comp_shift_reg.sv
// One-operand deserializing shift register.
// Build option: COMP_LOADER_LSB_FIRST_EN selects an LSB-first stream (default MSB first).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to zero (wins over en)
//   en         - shift din in this cycle
//   din        - serial data bit
//   shifted    - register contents with din shifted in (the value loaded on en)
module comp_shift_reg #(
    parameter int unsigned WIDTH = comp_pkg::COMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] sr_q;

`ifdef COMP_LOADER_LSB_FIRST_EN
    // First bit received ends up in bit 0 after WIDTH shifts.
    assign shifted = {din, sr_q[WIDTH-1:1]};
`else
    assign shifted = {sr_q[WIDTH-2:0], din};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q <= shifted;
        end
    end

endmodule

// File: rtl/comp_operand_loader.sv
// Operand loader for the 2-bit equality comparator: deserializes a bit-serial x/y pair stream
// into WIDTH-bit words and holds them behind a valid/ready handshake.
// Build option: COMP_LOADER_LSB_FIRST_EN (stream order, handled in comp_shift_reg).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - comp_operand_loader_if.slave: start/ser_* in, x/y/out_valid out, out_ready in,
//           busy (in SHIFT) and sticky overrun out
module comp_operand_loader
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH = COMP_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    comp_operand_loader_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, y_q;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    logic             sr_clr;
    logic             sr_en;
    logic             load_out;
    logic [WIDTH-1:0] xs_shifted;
    logic [WIDTH-1:0] ys_shifted;

    comp_shift_reg #(.WIDTH(WIDTH)) u_xs (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sr_clr),
        .en      (sr_en),
        .din     (bus.ser_x),
        .shifted (xs_shifted)
    );

    comp_shift_reg #(.WIDTH(WIDTH)) u_ys (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (sr_clr),
        .en      (sr_en),
        .din     (bus.ser_y),
        .shifted (ys_shifted)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        sr_clr      = 1'b0;
        sr_en       = 1'b0;
        load_out    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Any bit presented alongside start is dropped; capture starts next cycle.
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    sr_clr    = 1'b1;
                    overrun_d = 1'b0;
                end else if (bus.ser_valid) begin
                    overrun_d = 1'b1;
                end
            end

            SHIFT: begin
                if (bus.start) begin
                    // Abort and restart the current word.
                    cnt_d     = '0;
                    sr_clr    = 1'b1;
                    overrun_d = 1'b0;
                end else if (bus.ser_valid) begin
                    sr_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        load_out    = 1'b1;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            HOLD: begin
                if (bus.ser_valid) begin
                    overrun_d = 1'b1;
                end
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.start) begin
                        // Back-to-back load; an accepted start clears overrun even if a
                        // stray bit arrived in the same cycle.
                        state_d   = SHIFT;
                        cnt_d     = '0;
                        sr_clr    = 1'b1;
                        overrun_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            if (load_out) begin
                x_q <= xs_shifted;
                y_q <= ys_shifted;
            end
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_comp_operand_loader.sv
// Self-checking bench for comp_operand_loader: directed scenarios followed by randomized
// operand pairs, stall gaps, backpressure and stray serial bits, checked against a
// word-level model of the expected outputs.
module tb_comp_operand_loader;
    import comp_pkg::*;

    localparam int unsigned W = COMP_WIDTH_DEFAULT;

    logic clk;
    logic rst_n;

    comp_operand_loader_if #(.WIDTH(W)) bus ();

    comp_operand_loader #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Word-level model of the visible outputs.
    logic [W-1:0] m_x;
    logic [W-1:0] m_y;
    logic         m_valid;
    logic         m_busy;
    logic         m_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".x"}, 32'(bus.x), 32'(m_x));
        chk({tag, ".y"}, 32'(bus.y), 32'(m_y));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
        chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ov));
    endtask

    // Drive one cycle of inputs (at a negedge) and advance to the next negedge.
    task automatic drv(input logic st, input logic sv, input logic sx, input logic sy,
                       input logic rdy);
        bus.start     = st;
        bus.ser_valid = sv;
        bus.ser_x     = sx;
        bus.ser_y     = sy;
        bus.out_ready = rdy;
        @(negedge clk);
    endtask

    function automatic int bit_index(input int i);
`ifdef COMP_LOADER_LSB_FIRST_EN
        return i;
`else
        return W - 1 - i;
`endif
    endfunction

    // Stream one pair; optionally issue start first. stall idle cycles precede every bit.
    task automatic load_pair(input logic [W-1:0] xw, input logic [W-1:0] yw, input int stall,
                             input logic do_start, input string tag);
        if (do_start) begin
            drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            m_busy = 1'b1;
            m_valid = 1'b0;
            m_ov = 1'b0;
            chk_all({tag, ".start"});
        end
        for (int i = 0; i < int'(W); i++) begin
            for (int s = 0; s < stall; s++) begin
                drv(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                chk_all({tag, ".stall"});
            end
            drv(1'b0, 1'b1, xw[bit_index(i)], yw[bit_index(i)], 1'b0);
            if (i == int'(W) - 1) begin
                m_x = xw;
                m_y = yw;
                m_valid = 1'b1;
                m_busy = 1'b0;
            end
            chk_all({tag, ".bit"});
        end
    endtask

    // Hold the pair under backpressure; stray bits and unaccepted starts are allowed.
    task automatic hold_cycles(input int n, input logic stray, input string tag);
        for (int i = 0; i < n; i++) begin
            logic sv;
            sv = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            drv(1'($urandom_range(0, 1)), sv, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
            if (sv) m_ov = 1'b1;
            chk_all({tag, ".hold"});
        end
    endtask

    task automatic accept(input logic then_start, input string tag);
        drv(then_start, 1'b0, 1'b0, 1'b0, 1'b1);
        m_valid = 1'b0;
        m_busy = then_start;
        if (then_start) m_ov = 1'b0;
        chk_all({tag, ".accept"});
    endtask

    initial begin
        logic [W-1:0] xw;
        logic [W-1:0] yw;
        logic         b2b;
        logic         sv;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.ser_valid = 1'b0;
        bus.ser_x = 1'b0;
        bus.ser_y = 1'b0;
        bus.out_ready = 1'b0;
        m_x = '0;
        m_y = '0;
        m_valid = 1'b0;
        m_busy = 1'b0;
        m_ov = 1'b0;

        #1;
        chk_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("post_reset");

        // Basic pair, then release.
        load_pair(W'(2'b10), W'(2'b01), 0, 1'b1, "basic");
        accept(1'b0, "basic");

        // Stalls between bits.
        load_pair(W'(2'b11), W'(2'b11), 3, 1'b1, "stall");

        // Stray bit in IDLE after release sets overrun, x/y retained.
        accept(1'b0, "stall");
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        m_ov = 1'b1;
        chk_all("idle_stray");

        // Backpressure with stray bits; start+accept clears overrun and loads back-to-back.
        load_pair(W'(2'b01), W'(2'b10), 0, 1'b1, "bp");
        drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        m_ov = 1'b1;
        chk_all("bp.stray");
        hold_cycles(4, 1'b1, "bp");
        accept(1'b1, "b2b");
        load_pair(W'(2'b11), W'(2'b00), 0, 1'b0, "b2b");
        accept(1'b0, "b2b");

        // Start with a bit in the same cycle, one bit, then abort and reload.
        drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        m_busy = 1'b1;
        m_ov = 1'b0;
        chk_all("abort.start");
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("abort.bit");
        drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("abort.restart");
        load_pair(W'(2'b01), W'(2'b01), 0, 1'b0, "abort");
        accept(1'b0, "abort");

        // Randomized pairs.
        b2b = 1'b0;
        for (int n = 0; n < 24; n++) begin
            xw = W'($urandom);
            yw = W'($urandom);
            load_pair(xw, yw, int'($urandom_range(0, 2)), !b2b, "rnd");
            hold_cycles(int'($urandom_range(0, 3)), 1'b1, "rnd");
            b2b = 1'($urandom_range(0, 1));
            accept(b2b, "rnd");
            if (!b2b) begin
                sv = 1'($urandom_range(0, 1));
                drv(1'b0, sv, 1'b1, 1'b1, 1'b0);
                if (sv) m_ov = 1'b1;
                chk_all("rnd.idle");
            end
        end
        if (b2b) begin
            load_pair(W'(2'b10), W'(2'b10), 0, 1'b0, "rnd.tail");
            accept(1'b0, "rnd.tail");
        end

        // Asynchronous reset between clock edges in the middle of SHIFT.
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_busy = 1'b1;
        m_ov = 1'b0;
        chk_all("areset.start");
        drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("areset.bit");
        #2;
        rst_n = 1'b0;
        #1;
        m_x = '0;
        m_y = '0;
        m_valid = 1'b0;
        m_busy = 1'b0;
        m_ov = 1'b0;
        chk_all("areset.now");
        @(negedge clk);
        rst_n = 1'b1;
        // Partial word was discarded: a fresh load gives exactly the new pair.
        load_pair(W'(2'b10), W'(2'b01), 0, 1'b1, "after_reset");
        accept(1'b0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
